// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//
// Bundles every bus-side signal of the data-memory arbiter:
//   port A  (pipeline MEM stage):  a_req, a_we, a_addr, a_wdata, a_bsel  ->
//                                  a_gnt, a_stall, a_rvalid, a_rdata     <-
//   port B  (loader / DMA engine): b_req, b_we, b_addr, b_wdata, b_bsel  ->
//                                  b_gnt, b_rvalid, b_rdata              <-
//   memory side:                   mem_addr, mem_wdata, mem_ren, mem_wen,
//                                  mem_bsel                              <-
//                                  mem_rdata (one cycle after mem_ren)   ->
//
// Modport slave is the arbiter's view. Modport master is the view of
// whatever surrounds the arbiter: both requesters and the memory.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if;
   logic        a_req;
   logic        a_we;
   logic [31:0] a_addr;
   logic [31:0] a_wdata;
   logic [1:0]  a_bsel;
   logic        a_gnt;
   logic        a_stall;
   logic        a_rvalid;
   logic [31:0] a_rdata;

   logic        b_req;
   logic        b_we;
   logic [31:0] b_addr;
   logic [31:0] b_wdata;
   logic [1:0]  b_bsel;
   logic        b_gnt;
   logic        b_rvalid;
   logic [31:0] b_rdata;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ren;
   logic        mem_wen;
   logic [1:0]  mem_bsel;
   logic [31:0] mem_rdata;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata, a_bsel,
      output a_gnt, a_stall, a_rvalid, a_rdata,
      input  b_req, b_we, b_addr, b_wdata, b_bsel,
      output b_gnt, b_rvalid, b_rdata,
      output mem_addr, mem_wdata, mem_ren, mem_wen, mem_bsel,
      input  mem_rdata
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata, a_bsel,
      input  a_gnt, a_stall, a_rvalid, a_rdata,
      output b_req, b_we, b_addr, b_wdata, b_bsel,
      input  b_gnt, b_rvalid, b_rdata,
      input  mem_addr, mem_wdata, mem_ren, mem_wen, mem_bsel,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single data-memory port between the pipeline MEM stage
// (port A, fixed priority) and a secondary master (port B). A starvation
// counter gives port B the port after it has been pending and denied for
// STARVE_LIMIT consecutive cycles, so B waits at most STARVE_LIMIT+1 cycles
// under continuous A traffic.
//
// Grants are combinational in the request cycle. Read data comes back from
// the memory one cycle later and is steered to the port that issued the
// read by a registered two-bit response tag.
//
// Parameters:
//   STARVE_LIMIT  consecutive denied cycles before B wins (legal 1..15)
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active low
//   bus   dmem_arbiter_if.slave: both request ports plus the memory side
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;
   logic [1:0] rd_tag;      // bit0: A read outstanding, bit1: B read outstanding
   logic       b_priority;
   logic       a_gnt;
   logic       b_gnt;

   // ---- arbitration -------------------------------------------------------
   assign b_priority = (starve_cnt == LIMIT);

   // A wins unless B is also asking and has waited long enough.
   assign a_gnt = bus.a_req & ~(bus.b_req & b_priority);
   assign b_gnt = bus.b_req & ~a_gnt;

   assign bus.a_gnt   = a_gnt;
   assign bus.b_gnt   = b_gnt;
   assign bus.a_stall = bus.a_req & ~a_gnt;

   // ---- memory drive ------------------------------------------------------
   // Idle cycles drive zeros so the memory bus is quiet when nobody owns it.
   always_comb begin
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_bsel  = '0;
      bus.mem_ren   = 1'b0;
      bus.mem_wen   = 1'b0;
      if (a_gnt) begin
         bus.mem_addr  = bus.a_addr;
         bus.mem_wdata = bus.a_wdata;
         bus.mem_bsel  = bus.a_bsel;
         bus.mem_ren   = ~bus.a_we;
         bus.mem_wen   = bus.a_we;
      end else if (b_gnt) begin
         bus.mem_addr  = bus.b_addr;
         bus.mem_wdata = bus.b_wdata;
         bus.mem_bsel  = bus.b_bsel;
         bus.mem_ren   = ~bus.b_we;
         bus.mem_wen   = bus.b_we;
      end
   end

   // ---- starvation counter ------------------------------------------------
   // Counts only consecutive denied cycles; dropping b_req forgets history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (bus.b_req & ~b_gnt) begin
         if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
         end
      end else begin
         starve_cnt <= '0;
      end
   end

   // ---- response tag: request cycle -> response cycle ---------------------
   // Reset clears the tag, which drops any read still in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_tag <= 2'b00;
      end else begin
         rd_tag <= {b_gnt & ~bus.b_we, a_gnt & ~bus.a_we};
      end
   end

   assign bus.a_rvalid = rd_tag[0];
   assign bus.b_rvalid = rd_tag[1];
   assign bus.a_rdata  = rd_tag[0] ? bus.mem_rdata : 32'h0;
   assign bus.b_rdata  = rd_tag[1] ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
   localparam int LIMIT = 4;

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  bsel;
   } req_t;

   typedef struct {
      req_t        a;
      req_t        b;
      logic        e_agnt;
      logic        e_bgnt;
      logic        e_ren;
      logic        e_wen;
      logic        e_arv;
      logic        e_brv;
      logic [31:0] e_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_arbiter_if bus ();
   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Environment memory: writes and registered reads on the rising edge.
   logic [31:0] tmem [256];
   always @(posedge clk) begin
      if (bus.mem_wen) tmem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      if (bus.mem_ren) bus.mem_rdata <= tmem[bus.mem_addr[9:2]];
   end

   // Reference model state
   logic [31:0] ref_mem [256];
   int          b_wait;      // consecutive cycles B was pending and denied
   logic [1:0]  exp_tag;     // which port expects a response next cycle
   logic [31:0] exp_data;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic req_t rq(input logic r, input logic w, input logic [31:0] ad,
                               input logic [31:0] wd, input logic [1:0] bs);
      req_t x;
      x.req = r; x.we = w; x.addr = ad; x.wdata = wd; x.bsel = bs;
      return x;
   endfunction

   function automatic vec_t mkv(input req_t a, input req_t b, input logic ag, input logic bg,
                                input logic rn, input logic wn, input logic arv,
                                input logic brv, input logic [31:0] rd);
      vec_t v;
      v.a = a; v.b = b; v.e_agnt = ag; v.e_bgnt = bg; v.e_ren = rn; v.e_wen = wn;
      v.e_arv = arv; v.e_brv = brv; v.e_rdata = rd;
      return v;
   endfunction

   function automatic req_t rand_req();
      req_t x;
      x.req   = 1'b1;
      x.we    = ($urandom_range(0, 2) == 0);
      x.addr  = $urandom;
      x.wdata = $urandom;
      x.bsel  = 2'($urandom_range(0, 3));
      return x;
   endfunction

   task automatic drive(input req_t a, input req_t b);
      bus.a_req = a.req; bus.a_we = a.we; bus.a_addr = a.addr;
      bus.a_wdata = a.wdata; bus.a_bsel = a.bsel;
      bus.b_req = b.req; bus.b_we = b.we; bus.b_addr = b.addr;
      bus.b_wdata = b.wdata; bus.b_bsel = b.bsel;
   endtask

   // Checks one cycle at the falling edge against the rule-based model,
   // then advances the model to the next cycle.
   task automatic model_check(output logic ga, output logic gb);
      logic [31:0] ea, ew;
      logic [1:0]  eb;
      logic        er, ewn;
      @(negedge clk);
      ga = bus.a_req && !(bus.b_req && b_wait == LIMIT);
      gb = bus.b_req && !ga;
      ea = 32'h0; ew = 32'h0; eb = 2'b00; er = 1'b0; ewn = 1'b0;
      if (ga) begin
         ea = bus.a_addr; ew = bus.a_wdata; eb = bus.a_bsel; er = !bus.a_we; ewn = bus.a_we;
      end else if (gb) begin
         ea = bus.b_addr; ew = bus.b_wdata; eb = bus.b_bsel; er = !bus.b_we; ewn = bus.b_we;
      end
      chk("a_gnt", 32'(bus.a_gnt), 32'(ga));
      chk("b_gnt", 32'(bus.b_gnt), 32'(gb));
      chk("a_stall", 32'(bus.a_stall), 32'(bus.a_req && !ga));
      chk("mem_addr", bus.mem_addr, ea);
      chk("mem_wdata", bus.mem_wdata, ew);
      chk("mem_bsel", 32'(bus.mem_bsel), 32'(eb));
      chk("mem_ren", 32'(bus.mem_ren), 32'(er));
      chk("mem_wen", 32'(bus.mem_wen), 32'(ewn));
      chk("a_rvalid", 32'(bus.a_rvalid), 32'(exp_tag[0]));
      chk("b_rvalid", 32'(bus.b_rvalid), 32'(exp_tag[1]));
      chk("a_rdata", bus.a_rdata, exp_tag[0] ? exp_data : 32'h0);
      chk("b_rdata", bus.b_rdata, exp_tag[1] ? exp_data : 32'h0);
      exp_tag = 2'b00;
      if (er) begin
         exp_tag  = ga ? 2'b01 : 2'b10;
         exp_data = ref_mem[ea[9:2]];
      end
      if (ewn) ref_mem[ea[9:2]] = ew;
      if (bus.b_req && !gb) b_wait = (b_wait < LIMIT) ? b_wait + 1 : LIMIT;
      else                  b_wait = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(output logic ga, output logic gb);
      model_check(ga, gb);
      tick();
   endtask

   req_t idle, ra, rb;
   vec_t tv [12];
   logic ga, gb;

   initial begin
      idle = rq(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
      for (int i = 0; i < 256; i++) begin
         tmem[i] = 32'h0; ref_mem[i] = 32'h0;
      end
      tmem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;   // 0x10
      tmem[1] = 32'h00000011; ref_mem[1] = 32'h00000011;   // 0x4
      tmem[2] = 32'h00000022; ref_mem[2] = 32'h00000022;   // 0x8
      bus.mem_rdata = 32'h0;

      // Hand-derived vectors, one row per cycle, starting right out of reset.
      tv[0]  = mkv(idle, idle, 0, 0, 0, 0, 0, 0, 32'h0);
      tv[1]  = mkv(rq(1, 0, 32'h10, 32'h0, 2'b10), idle, 1, 0, 1, 0, 0, 0, 32'h0);
      tv[2]  = mkv(idle, idle, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF);
      tv[3]  = mkv(rq(1, 0, 32'h4, 32'h0, 2'b10), idle, 1, 0, 1, 0, 0, 0, 32'h0);
      tv[4]  = mkv(idle, rq(1, 0, 32'h8, 32'h0, 2'b10), 0, 1, 1, 0, 1, 0, 32'h11);
      tv[5]  = mkv(idle, idle, 0, 0, 0, 0, 0, 1, 32'h22);
      tv[6]  = mkv(idle, rq(1, 1, 32'h8, 32'hCAFEF00D, 2'b10), 0, 1, 0, 1, 0, 0, 32'h0);
      tv[7]  = mkv(rq(1, 0, 32'h8, 32'h0, 2'b10), idle, 1, 0, 1, 0, 0, 0, 32'h0);
      tv[8]  = mkv(idle, idle, 0, 0, 0, 0, 1, 0, 32'hCAFEF00D);
      tv[9]  = mkv(rq(1, 0, 32'h4, 32'h0, 2'b00), rq(1, 0, 32'h8, 32'h0, 2'b01),
                   1, 0, 1, 0, 0, 0, 32'h0);
      tv[10] = mkv(rq(1, 1, 32'h40, 32'h55, 2'b10), rq(1, 0, 32'h8, 32'h0, 2'b01),
                   1, 0, 0, 1, 1, 0, 32'h11);
      tv[11] = mkv(idle, idle, 0, 0, 0, 0, 0, 0, 32'h0);

      // Reset state
      rst = 1'b0;
      drive(idle, idle);
      b_wait = 0; exp_tag = 2'b00; exp_data = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_gnt", 32'(bus.a_gnt), 32'h0);
      chk("rst_b_gnt", 32'(bus.b_gnt), 32'h0);
      chk("rst_rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'h0);
      chk("rst_rdata", bus.a_rdata | bus.b_rdata, 32'h0);
      chk("rst_mem_ctl", 32'({bus.mem_ren, bus.mem_wen, bus.mem_bsel}), 32'h0);
      chk("rst_mem_addr", bus.mem_addr | bus.mem_wdata, 32'h0);
      rst = 1'b1;
      tick();

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         drive(tv[i].a, tv[i].b);
         model_check(ga, gb);
         chk($sformatf("tv%0d_a_gnt", i), 32'(bus.a_gnt), 32'(tv[i].e_agnt));
         chk($sformatf("tv%0d_b_gnt", i), 32'(bus.b_gnt), 32'(tv[i].e_bgnt));
         chk($sformatf("tv%0d_ren", i), 32'(bus.mem_ren), 32'(tv[i].e_ren));
         chk($sformatf("tv%0d_wen", i), 32'(bus.mem_wen), 32'(tv[i].e_wen));
         chk($sformatf("tv%0d_a_rvalid", i), 32'(bus.a_rvalid), 32'(tv[i].e_arv));
         chk($sformatf("tv%0d_b_rvalid", i), 32'(bus.b_rvalid), 32'(tv[i].e_brv));
         chk($sformatf("tv%0d_a_rdata", i), bus.a_rdata, tv[i].e_arv ? tv[i].e_rdata : 32'h0);
         chk($sformatf("tv%0d_b_rdata", i), bus.b_rdata, tv[i].e_brv ? tv[i].e_rdata : 32'h0);
         tick();
      end

      // Contention: B wins every fifth cycle under continuous A traffic.
      drive(rq(1, 0, 32'h100, 32'h0, 2'b10), rq(1, 0, 32'h200, 32'h0, 2'b10));
      for (int c = 1; c <= 10; c++) begin
         model_check(ga, gb);
         chk($sformatf("cont%0d_b_gnt", c), 32'(bus.b_gnt), 32'((c % 5) == 0));
         chk($sformatf("cont%0d_a_stall", c), 32'(bus.a_stall), 32'((c % 5) == 0));
         tick();
      end

      // Idle B: two denied cycles, drop, then a fresh full wait.
      for (int c = 1; c <= 8; c++) begin
         drive(rq(1, 1, 32'h300, 32'h77, 2'b01),
               (c == 3) ? idle : rq(1, 0, 32'h204, 32'h0, 2'b10));
         model_check(ga, gb);
         chk($sformatf("idleb%0d_b_gnt", c), 32'(bus.b_gnt), 32'(c == 8));
         tick();
      end

      // Reset in the middle of a granted read.
      drive(rq(1, 0, 32'h10, 32'h0, 2'b10), idle);
      model_check(ga, gb);
      chk("rmid_a_gnt", 32'(bus.a_gnt), 32'h1);
      #2;
      rst = 1'b0;
      drive(idle, idle);
      exp_tag = 2'b00; b_wait = 0;
      tick();
      chk("rmid_a_rvalid", 32'(bus.a_rvalid), 32'h0);
      chk("rmid_outputs", 32'({bus.a_gnt, bus.b_gnt, bus.a_stall, bus.b_rvalid,
                               bus.mem_ren, bus.mem_wen, bus.mem_bsel}), 32'h0);
      chk("rmid_buses", bus.a_rdata | bus.b_rdata | bus.mem_addr | bus.mem_wdata, 32'h0);
      tick();
      rst = 1'b1;
      cycle(ga, gb);
      chk("rrel_a_rvalid", 32'(bus.a_rvalid), 32'h0);

      // Randomized traffic with requesters that hold until granted.
      ra = idle; rb = idle;
      for (int n = 0; n < 3000; n++) begin
         if (!ra.req && $urandom_range(0, 7) != 0) ra = rand_req();
         if (!rb.req && $urandom_range(0, 1) != 0) rb = rand_req();
         drive(ra, rb);
         cycle(ga, gb);
         if (ga) ra.req = 1'b0;
         if (gb) rb.req = 1'b0;
      end

      drive(idle, idle);
      cycle(ga, gb);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter that shares the single data-memory port between the pipeline MEM stage (port A) and a secondary master such as a loader or DMA engine (port B). Port A has fixed priority, backed by a starvation counter that guarantees port B a slot after a bounded wait. The block drives the memory's address, enable, write-data and byte-select inputs. It routes the one-cycle-late read data back to whichever port issued the read, and gives the pipeline a stall signal for cycles where the MEM stage loses arbitration.

## Interface
- STARVE_LIMIT, default 4: number of consecutive cycles port B may be pending and denied before it gets priority; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- a_req  in  1  port A access request (MEM stage load/store).
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  32  port A byte address.
- a_wdata  in  32  port A store data.
- a_bsel  in  2  port A byte select; passed to the memory unchanged.
- a_gnt  out  1  port A access issued this cycle.
- a_stall  out  1  equals a_req & ~a_gnt; freezes the pipeline.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  32  port A read data.
- b_req, b_we, b_addr[31:0], b_wdata[31:0], b_bsel[1:0]  in: port B equivalents of the port A request inputs.
- b_gnt, b_rvalid, b_rdata[31:0]  out: port B equivalents of the port A response outputs.
- mem_addr  out  32  to data memory.
- mem_wdata  out  32  to data memory.
- mem_ren  out  1  memory read enable.
- mem_wen  out  1  memory write enable.
- mem_bsel  out  2  to data memory.
- mem_rdata  in  32  memory read data; valid one cycle after mem_ren.

## Operation
- **Grant rule (combinational each cycle):**
  - Only A requests: grant A.
  - Only B requests: grant B.
  - Both request: grant A unless starve_cnt == STARVE_LIMIT, in which case grant B.
  - Neither requests: no grant, mem_ren = mem_wen = 0, mem_addr/mem_wdata/mem_bsel = 0.
- **Memory drive:** the granted port's addr, wdata and bsel drive the mem_* outputs.
  - mem_ren = granted & ~we.
  - mem_wen = granted & we.
- **Requester hold:** a requester holds req and all request fields stable until it sees gnt.
  - The cycle in which gnt = 1 completes the request.
  - Keeping req high after that starts a new access.
- **starve_cnt (4-bit register):**
  - Increments when b_req = 1 and b_gnt = 0.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on b_gnt, or when b_req = 0.
- **Response tag (registered):**
  - rd_tag = 2'b01 after a granted A read, 2'b10 after a granted B read, 2'b00 otherwise (writes or idle).
  - a_rvalid = rd_tag[0]; b_rvalid = rd_tag[1].
  - a_rdata = a_rvalid ? mem_rdata : 0; b_rdata is the same using b_rvalid.
- Writes produce no response.
- The block performs no address decoding and no sign/zero extension; load extension stays in the MEM stage.

## Timing
- **Grant timing:** grant is combinational in the request cycle, so a lone request is issued in cycle N with no wait.
- **Read latency:** a read granted in cycle N has rvalid = 1 for exactly cycle N+1, with mem_rdata passed through.
- **Back-to-back:** one access per cycle. A read in N and a read in N+1 give responses in N+1 and N+2, possibly to different ports.
- **Worst-case B wait** under continuous A traffic: STARVE_LIMIT+1 cycles from b_req rising to b_gnt. A stalls for exactly that one cycle.
- **Write then read, same address:** the write in N and the read in N+1 return the new data, provided the memory writes on the clock edge ending cycle N.
- **Simultaneous read and write:** impossible by construction, since exactly one port is granted.
- **Reset values:** rd_tag = 0 and starve_cnt = 0. With both reqs low this gives all gnt, rvalid, rdata and mem_* outputs = 0.
- **Reset mid-read:** an outstanding read response is dropped, with no rvalid after deassertion. Requesters must re-issue.
- **Reset release:** the first cycle after deassertion arbitrates normally.

## Test plan
- **Lone A read:** a_req=1, a_we=0, a_addr=0x10, memory holds 0xDEADBEEF → a_gnt=1 and mem_ren=1 in cycle N; a_rvalid=1 and a_rdata=0xDEADBEEF in N+1; b_rvalid=0.
- **Contention:** a_req and b_req both held high for 8 cycles, STARVE_LIMIT=4 → b_gnt=1 only in cycle 5 (count from 1); a_stall=1 in that cycle only; starve_cnt returns to 0 in cycle 6.
- **Interleaved reads:** A read addr 0x4 (data 0x11) in N, B read addr 0x8 (data 0x22) in N+1 → a_rvalid with 0x11 in N+1, b_rvalid with 0x22 in N+2, never both high in the same cycle.
- **Write/read ordering:** B write 0x8 := 0xCAFEF00D, bsel=2'b10, in N; A read 0x8 in N+1 → a_rdata=0xCAFEF00D in N+2; mem_wen=1 only in N.
- **Reset mid-read:** A read granted in N, rst=0 asynchronously mid-N → a_rvalid stays 0 in N+1 and after release; all outputs 0 while rst=0.
- **Idle B:** b_req dropped after 2 denied cycles → starve_cnt clears; on re-request B again waits STARVE_LIMIT cycles.
